// File: rtl/if_aligner_pkg.sv
// Shared RV32IC front-end definitions used by the instruction aligner.
//   ILEN_C / ILEN_W : compressed / full instruction widths in bits
//   is_compressed   : length decode from the low halfword of an instruction
//   fetch_pkt_t     : one fetch beat (word address + word)
package rv_pkg;

    localparam int unsigned ILEN_C = 16;
    localparam int unsigned ILEN_W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_pkt_t;

    // Anything other than 2'b11 in the low bits is a 16-bit encoding.
    function automatic logic is_compressed(input logic [ILEN_C-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/if_aligner_if.sv
// Fetch-side and decode-side signals of the instruction aligner.
//   slave  : view of the aligner (consumes fetch/flush/id_ready, drives the rest)
//   master : view of the surrounding pipeline (fetch stage + decode)
interface if_aligner_if;

    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_word;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic        id_compressed;
    logic [31:0] id_pc;

    modport slave (
        input  fetch_valid, fetch_pc, fetch_word, flush, flush_pc, id_ready,
        output fetch_ready, id_valid, id_instr, id_compressed, id_pc
    );

    modport master (
        output fetch_valid, fetch_pc, fetch_word, flush, flush_pc, id_ready,
        input  fetch_ready, id_valid, id_instr, id_compressed, id_pc
    );

endinterface

// File: rtl/if_aligner_hwq.sv
// 4-entry halfword queue for the instruction aligner.
//   clk, reset          : clock, synchronous active-high reset
//   clear_i             : discard all entries (redirect)
//   pop_n_i             : halfwords removed from the head this cycle (0..2)
//   push_n_i            : halfwords appended this cycle (0..2), hw0 first
//   push_hw0_i/_hw1_i   : data to append
//   hw0_o, hw1_o        : head and second entry
//   cnt_o               : number of valid entries (0..4)
// Pop is applied before push; the caller guarantees no underflow/overflow.
module aligner_hwq (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic [1:0]  pop_n_i,
    input  logic [1:0]  push_n_i,
    input  logic [15:0] push_hw0_i,
    input  logic [15:0] push_hw1_i,
    output logic [15:0] hw0_o,
    output logic [15:0] hw1_o,
    output logic [2:0]  cnt_o
);

    logic [15:0] hw_q [4];
    logic [15:0] hw_d [4];
    logic [15:0] shift [4];
    logic [2:0]  cnt_q, cnt_d, base;

    always_comb begin
        shift = hw_q;
        case (pop_n_i)
            2'd1: begin
                shift[0] = hw_q[1];
                shift[1] = hw_q[2];
                shift[2] = hw_q[3];
                shift[3] = '0;
            end
            2'd2: begin
                shift[0] = hw_q[2];
                shift[1] = hw_q[3];
                shift[2] = '0;
                shift[3] = '0;
            end
            default: ;
        endcase

        // New data lands right behind whatever survived the pop.
        base  = cnt_q - {1'b0, pop_n_i};
        hw_d  = shift;
        for (int unsigned i = 0; i < 4; i++) begin
            if (3'(i) == base && push_n_i != 2'd0)
                hw_d[i] = push_hw0_i;
            else if (3'(i) == base + 3'd1 && push_n_i == 2'd2)
                hw_d[i] = push_hw1_i;
        end
        cnt_d = base + {1'b0, push_n_i};

        if (clear_i) begin
            hw_d  = '{default: '0};
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hw_q  <= '{default: '0};
            cnt_q <= '0;
        end else begin
            hw_q  <= hw_d;
            cnt_q <= cnt_d;
        end
    end

    assign hw0_o = hw_q[0];
    assign hw1_o = hw_q[1];
    assign cnt_o = cnt_q;

endmodule

// File: rtl/if_aligner.sv
// Instruction aligner between fetch and decode (RV32IC).
// Buffers word-aligned fetch words as halfwords and hands decode one whole
// instruction (16- or 32-bit, possibly straddling two words) per handshake,
// together with its PC. Redirects may target any halfword address.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch handshake, flush redirect and decode handshake
// Parameter RESET_PC: PC of the first instruction after reset.
module if_aligner
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    if_aligner_if.slave  bus
);

    logic [15:0] hw0, hw1;
    logic [2:0]  cnt;
    logic        head_c;
    logic        id_valid_w;
    logic        fire;
    logic        fetch_ready_w;
    logic        accept;
    logic [1:0]  pop_n, push_n;
    logic [15:0] push_hw0;
    fetch_pkt_t  pkt;

    logic [31:0] head_pc_q, head_pc_d;
    logic        drop_low_q, drop_low_d;
    logic [29:0] next_fa_q;
    logic        unused_bits;

    assign pkt = '{pc: bus.fetch_pc, word: bus.fetch_word};

    assign head_c        = is_compressed(hw0);
    assign id_valid_w    = (cnt >= 3'd1 && head_c) || (cnt >= 3'd2);
    assign fire          = id_valid_w && bus.id_ready;
    assign fetch_ready_w = (cnt <= 3'd2);
    assign accept        = bus.fetch_valid && fetch_ready_w;

    // The queue clear wins over these during a flush, so they need no gating.
    assign pop_n    = fire ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    assign push_n   = accept ? (drop_low_q ? 2'd1 : 2'd2) : 2'd0;
    assign push_hw0 = drop_low_q ? pkt.word[31:16] : pkt.word[15:0];

    aligner_hwq u_hwq (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (bus.flush),
        .pop_n_i    (pop_n),
        .push_n_i   (push_n),
        .push_hw0_i (push_hw0),
        .push_hw1_i (pkt.word[31:16]),
        .hw0_o      (hw0),
        .hw1_o      (hw1),
        .cnt_o      (cnt)
    );

    always_comb begin
        head_pc_d  = head_pc_q;
        drop_low_d = drop_low_q;
        if (bus.flush) begin
            head_pc_d  = {bus.flush_pc[31:1], 1'b0};
            drop_low_d = bus.flush_pc[1];
        end else begin
            if (fire)
                head_pc_d = head_pc_q + (head_c ? 32'd2 : 32'd4);
            if (accept)
                drop_low_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_pc_q  <= RESET_PC;
            drop_low_q <= RESET_PC[1];
        end else begin
            head_pc_q  <= head_pc_d;
            drop_low_q <= drop_low_d;
        end
    end

    // Upstream is expected to deliver sequential words starting at the
    // word containing the redirect target; tracked only for the check below.
    always_ff @(posedge clk) begin
        if (reset)
            next_fa_q <= RESET_PC[31:2];
        else if (bus.flush)
            next_fa_q <= bus.flush_pc[31:2];
        else if (accept)
            next_fa_q <= next_fa_q + 30'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && accept)
            assert (pkt.pc[31:2] == next_fa_q);
    end

    assign unused_bits = ^{pkt.pc[1:0]};

    assign bus.fetch_ready   = fetch_ready_w;
    assign bus.id_valid      = id_valid_w;
    assign bus.id_compressed = id_valid_w && head_c;
    assign bus.id_instr      = !id_valid_w ? '0 :
                               head_c      ? {16'h0000, hw0} : {hw1, hw0};
    assign bus.id_pc         = head_pc_q;

endmodule
